// File: rtl/memory_access.sv
// Memory stage of a Y86-64 style pipeline: a byte-addressed little-endian
// data memory with a fixed multi-cycle access latency. Each accepted start
// runs one instruction's memory phase, then pulses done for one cycle.
module memory_access #(
    parameter int MEM_BYTES = 1024,
    parameter int LAT       = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  icode,
    input  logic [63:0] valE,
    input  logic [63:0] valA,
    input  logic [63:0] valP,
    output logic [63:0] valM,
    output logic        dmem_error,
    output logic        busy,
    output logic        done
);

    localparam int          AW       = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
    localparam logic [63:0] MAX_ADDR = 64'(MEM_BYTES - 8);
    localparam logic [3:0]  LAST_CNT = 4'(LAT - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t      state, next_state;
    logic [3:0]  cnt;
    logic [3:0]  op_icode;
    logic [63:0] op_valE, op_valA, op_valP;

    // NOTE: the memory array has no reset; contents survive rst and start at zero in simulation.
    logic [7:0]  mem [MEM_BYTES] = '{default: 8'h00};

    logic        is_write, is_read, addr_err, last_access, commit_write;
    logic [63:0] addr, wdata, rdata;
    logic [AW-1:0] base;

    function automatic logic is_mem_op(input logic [3:0] c);
        return c inside {4'd4, 4'd5, 4'd8, 4'd9, 4'd10, 4'd11};
    endfunction

    // Decode the latched instruction into access kind, address and write data.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        is_write = op_icode inside {4'd4, 4'd8, 4'd10};
        is_read  = op_icode inside {4'd5, 4'd9, 4'd11};
        addr     = (op_icode == 4'd9 || op_icode == 4'd11) ? op_valA : op_valE;
        wdata    = (op_icode == 4'd8) ? op_valP : op_valA;
        base     = addr[AW-1:0];
        // Unsigned 64-bit compare, so wrapped addresses near 2^64 are rejected too.
        addr_err = addr > MAX_ADDR;
    end

    // Assemble the little-endian 8-byte word starting at the access address.
    always_comb begin
        rdata = '0;
        for (int i = 0; i < 8; i++) begin
            rdata[8*i +: 8] = mem[base + AW'(i)];
        end
    end

    assign last_access  = (state == ACCESS) && (cnt == LAST_CNT);
    // Reset on the commit edge still wins, so an aborted store never lands.
    assign commit_write = last_access && is_write && !addr_err && !rst;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments to avoid read/write races between processes.
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state and handshake outputs.
    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) next_state = is_mem_op(icode) ? ACCESS : DONE;
            end
            ACCESS: begin
                busy = 1'b1;
                if (cnt == LAST_CNT) next_state = DONE;
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Access-cycle counter: zero outside ACCESS, so it is clear on entry.
    always_ff @(posedge clk) begin
        if (rst)                  cnt <= 4'd0;
        else if (state == ACCESS) cnt <= cnt + 4'd1;
        else                      cnt <= 4'd0;
    end

    // Capture the instruction operands when a start is accepted.
    always_ff @(posedge clk) begin
        if (!rst && state == IDLE && start) begin
            op_icode <= icode;
            op_valE  <= valE;
            op_valA  <= valA;
            op_valP  <= valP;
        end
    end

    // Result registers: updated only when an operation completes, held otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            valM       <= '0;
            dmem_error <= 1'b0;
        end else if (state == IDLE && start && !is_mem_op(icode)) begin
            valM       <= '0;
            dmem_error <= 1'b0;
        end else if (last_access) begin
            dmem_error <= addr_err;
            valM       <= (is_read && !addr_err) ? rdata : '0;
        end
    end

    // Byte-wise store of the full word on the commit edge.
    always_ff @(posedge clk) begin
        if (commit_write) begin
            for (int i = 0; i < 8; i++) begin
                mem[base + AW'(i)] <= wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access with MEM_BYTES=1024, LAT=2.
module tb_memory_access;

    localparam int MEM_BYTES = 1024;
    localparam int LAT       = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  icode;
    logic [63:0] valE, valA, valP;
    logic [63:0] valM;
    logic        dmem_error, busy, done;

    int checks = 0;
    int errors = 0;

    memory_access #(.MEM_BYTES(MEM_BYTES), .LAT(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .icode      (icode),
        .valE       (valE),
        .valA       (valA),
        .valP       (valP),
        .valM       (valM),
        .dmem_error (dmem_error),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Issue one instruction, scramble the inputs after acceptance, and return
    // the number of rising edges until done is seen (-1 on timeout).
    task automatic run_op(input logic [3:0] ic, input logic [63:0] e, input logic [63:0] a,
                          input logic [63:0] p, output int lat);
        @(negedge clk);
        icode = ic; valE = e; valA = a; valP = p; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        icode = 4'h4; valE = 64'h30; valA = 64'hFEED; valP = 64'hBEEF;
        lat = 1;
        while (!done && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        if (!done) lat = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; icode = '0; valE = '0; valA = '0; valP = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, dmem_error} !== 3'b000 || valM !== 64'h0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b err=%b valM=%h, required all zero",
                     busy, done, dmem_error, valM);
        end
        rst = 1'b0;
    endtask

    task automatic test_write_read();
        int lat;
        run_op(4'd4, 64'h10, 64'h1122334455667788, 64'h999, lat);
        checks++;
        if (lat !== LAT + 1) begin errors++; $display("FAIL wr_latency: got %0d required %0d", lat, LAT + 1); end
        checks++;
        if (valM !== 64'h0 || dmem_error !== 1'b0) begin
            errors++; $display("FAIL wr_result: valM=%h err=%b required 0/0", valM, dmem_error);
        end
        run_op(4'd5, 64'h10, 64'h0, 64'h0, lat);
        checks++;
        if (lat !== LAT + 1) begin errors++; $display("FAIL rd_latency: got %0d required %0d", lat, LAT + 1); end
        checks++;
        if (valM !== 64'h1122334455667788) begin
            errors++; $display("FAIL rd_after_wr: got %h required 1122334455667788", valM);
        end
        // Unaligned read one byte lower: byte 0x0F is zero, byte 0x10 holds 0x88.
        run_op(4'd5, 64'h0F, 64'h0, 64'h0, lat);
        checks++;
        if (valM !== 64'h2233445566778800) begin
            errors++; $display("FAIL rd_unaligned: got %h required 2233445566778800", valM);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (valM !== 64'h2233445566778800 || done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL hold_after_done: valM=%h done=%b busy=%b", valM, done, busy);
        end
    endtask

    task automatic test_stack();
        int lat;
        run_op(4'd10, 64'h100, 64'hDEAD, 64'h0, lat);
        checks++;
        if (lat !== LAT + 1 || valM !== 64'h0) begin
            errors++; $display("FAIL pushq: lat=%0d valM=%h required %0d/0", lat, valM, LAT + 1);
        end
        run_op(4'd11, 64'h0, 64'h100, 64'h0, lat);
        checks++;
        if (valM !== 64'hDEAD) begin errors++; $display("FAIL popq: got %h required dead", valM); end
        run_op(4'd8, 64'hF8, 64'h77, 64'h40, lat);
        checks++;
        if (valM !== 64'h0 || dmem_error !== 1'b0) begin
            errors++; $display("FAIL call: valM=%h err=%b required 0/0", valM, dmem_error);
        end
        run_op(4'd9, 64'h500, 64'hF8, 64'h0, lat);
        checks++;
        if (valM !== 64'h40) begin errors++; $display("FAIL ret: got %h required 40", valM); end
    endtask

    task automatic test_range();
        int lat;
        run_op(4'd5, 64'(MEM_BYTES - 7), 64'h0, 64'h0, lat);
        checks++;
        if (dmem_error !== 1'b1 || valM !== 64'h0) begin
            errors++; $display("FAIL rd_oob: err=%b valM=%h required 1/0", dmem_error, valM);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (dmem_error !== 1'b1) begin errors++; $display("FAIL err_hold: got %b required 1", dmem_error); end
        run_op(4'd4, 64'hFFFF_FFFF_FFFF_FFFC, 64'h99, 64'h0, lat);
        checks++;
        if (dmem_error !== 1'b1 || valM !== 64'h0) begin
            errors++; $display("FAIL wr_wrap: err=%b valM=%h required 1/0", dmem_error, valM);
        end
        run_op(4'd5, 64'(MEM_BYTES - 8), 64'h0, 64'h0, lat);
        checks++;
        if (dmem_error !== 1'b0 || valM !== 64'h0) begin
            errors++; $display("FAIL rd_last_word: err=%b valM=%h required 0/0", dmem_error, valM);
        end
        run_op(4'd5, 64'h0, 64'h0, 64'h0, lat);
        checks++;
        if (valM !== 64'h0) begin errors++; $display("FAIL wrap_untouched: got %h required 0", valM); end
        run_op(4'd4, 64'(MEM_BYTES - 8), 64'h0102030405060708, 64'h0, lat);
        run_op(4'd5, 64'(MEM_BYTES - 8), 64'h0, 64'h0, lat);
        checks++;
        if (valM !== 64'h0102030405060708 || dmem_error !== 1'b0) begin
            errors++; $display("FAIL last_word_rw: valM=%h err=%b required 0102030405060708/0", valM, dmem_error);
        end
    endtask

    task automatic test_nonmem();
        int lat;
        run_op(4'd5, 64'h10, 64'h0, 64'h0, lat);   // leave valM non-zero
        run_op(4'd6, 64'h10, 64'h55, 64'h66, lat);
        checks++;
        if (lat !== 1 || valM !== 64'h0 || dmem_error !== 1'b0) begin
            errors++; $display("FAIL opq: lat=%0d valM=%h err=%b required 1/0/0", lat, valM, dmem_error);
        end
        run_op(4'd5, 64'h10, 64'h0, 64'h0, lat);
        checks++;
        if (valM !== 64'h1122334455667788) begin
            errors++; $display("FAIL opq_no_write: got %h required 1122334455667788", valM);
        end
    endtask

    task automatic test_reset_abort();
        int lat;
        int seen_done;
        run_op(4'd4, 64'h200, 64'h5555, 64'h0, lat);
        @(negedge clk);
        icode = 4'd4; valE = 64'h200; valA = 64'hAAAA; start = 1'b1;
        @(negedge clk);                 // first ACCESS cycle
        start = 1'b0;
        @(negedge clk);                 // second ACCESS cycle: reset hits the commit edge
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || valM !== 64'h0) begin
            errors++; $display("FAIL abort_idle: busy=%b done=%b valM=%h required 0/0/0", busy, done, valM);
        end
        seen_done = 0;
        repeat (5) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        checks++;
        if (seen_done !== 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses required 0", seen_done); end
        run_op(4'd5, 64'h200, 64'h0, 64'h0, lat);
        checks++;
        if (valM !== 64'h5555) begin errors++; $display("FAIL abort_no_write: got %h required 5555", valM); end
    endtask

    task automatic test_busy_ignore();
        @(negedge clk);
        icode = 4'd5; valE = 64'h10; start = 1'b1;
        @(negedge clk);                 // ACCESS: present a store while busy
        icode = 4'd4; valE = 64'h10; valA = 64'hBAD;
        @(negedge clk);
        @(negedge clk);                 // DONE
        checks++;
        if (done !== 1'b1 || valM !== 64'h1122334455667788) begin
            errors++; $display("FAIL busy_read: done=%b valM=%h required 1/1122334455667788", done, valM);
        end
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL busy_return_idle: busy=%b done=%b required 0/0", busy, done);
        end
        begin
            int lat;
            run_op(4'd5, 64'h10, 64'h0, 64'h0, lat);
            checks++;
            if (valM !== 64'h1122334455667788) begin
                errors++; $display("FAIL busy_start_ignored: got %h required 1122334455667788", valM);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_stack();
        test_range();
        test_nonmem();
        test_reset_abort();
        test_busy_ignore();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
